// File: rtl/cam_pkg.sv
// Shared encodings for the DVP capture path: pixel formats, FSM states, RGB565 field positions
// and small arithmetic helpers.
package cam_pkg;

  typedef enum logic [1:0] {
    FMT_RGB332 = 2'd0,
    FMT_RGB444 = 2'd1,
    FMT_RGB565 = 2'd2,
    FMT_GRAY8  = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_LINE  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int R_HI = 15;
  localparam int R_LO = 11;
  localparam int G_HI = 10;
  localparam int G_LO = 5;
  localparam int B_HI = 4;
  localparam int B_LO = 0;

  // R and B are widened to 6 bits by MSB replication so all three channels share one scale.
  function automatic logic [7:0] gray8(input logic [4:0] r, input logic [5:0] g, input logic [4:0] b);
    return {2'b00, r, r[4]} + {1'b0, g, 1'b0} + {2'b00, b, b[4]};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cam_px_fmt.sv
// Combinational RGB565 byte pair -> selected output format, zero-extended into DW bits.
module cam_px_fmt
  import cam_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [7:0]    hi,
  input  logic [7:0]    lo,
  input  fmt_e          fmt,
  output logic [DW-1:0] px
);

  logic [15:0] rgb;
  logic [4:0]  r;
  logic [5:0]  g;
  logic [4:0]  b;
  logic [15:0] wide;

  assign rgb = {hi, lo};
  assign r   = rgb[R_HI:R_LO];
  assign g   = rgb[G_HI:G_LO];
  assign b   = rgb[B_HI:B_LO];

  always_comb begin
    wide = 16'd0;
    case (fmt)
      FMT_RGB332: wide = {8'd0, r[4:2], g[5:3], b[4:3]};
      FMT_RGB444: wide = {4'd0, r[4:1], g[5:2], b[4:1]};
      FMT_RGB565: wide = rgb;
      FMT_GRAY8:  wide = {8'd0, gray8(r, g, b)};
      default:    wide = 16'd0;
    endcase
  end

  assign px = wide[DW-1:0];

endmodule

// File: rtl/cam_capture_fmt.sv
// DVP camera capture: frame/line FSM, byte pairing, optional 2x2 decimation, raster address
// generation with clamping, snapshot hold, frame statistics and geometry error flag.
module cam_capture_fmt
  import cam_pkg::*;
#(
  parameter int AW    = 17,
  parameter int DW    = 16,
  parameter int H_RES = 320,
  parameter int V_RES = 240,
  parameter int DECIM = 0
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  input  logic [1:0]    fmt,
  input  logic          snap,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic [7:0]    frame_cnt,
  output logic          frozen,
  output logic          err_geom
);

  localparam logic [15:0]   H_IN   = 16'(H_RES * (DECIM + 1));
  localparam logic [15:0]   H_LIM  = 16'(H_RES);
  localparam logic [15:0]   V_LIM  = 16'(V_RES);
  localparam logic [AW-1:0] H_STEP = AW'(H_RES);

  state_e        state, state_nxt;
  logic          vsync_d, href_d, phase;
  logic [7:0]    hi_byte;
  fmt_e          fmt_lat;
  logic [15:0]   in_col, in_row, col, row;
  logic [AW-1:0] wr_addr, row_base;
  logic [DW-1:0] px_conv;
  logic          vs_rise, vs_fall, hr_rise;
  logic          frame_start, line_start, byte_in, line_end, frame_end;
  logic          keep_px, keep_line, wr_ok;

  assign vs_rise   = vsync & ~vsync_d;
  assign vs_fall   = ~vsync & vsync_d;
  assign hr_rise   = href & ~href_d;
  assign keep_px   = (DECIM == 0) ? 1'b1 : (~in_col[0] & ~in_row[0]);
  assign keep_line = (DECIM == 0) ? 1'b1 : ~in_row[0];
  assign wr_ok     = (col < H_LIM) && (row < V_LIM);

  cam_px_fmt #(.DW(DW)) u_fmt (
    .hi  (hi_byte),
    .lo  (px_data),
    .fmt (fmt_lat),
    .px  (px_conv)
  );

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    line_start  = 1'b0;
    byte_in     = 1'b0;
    line_end    = 1'b0;
    frame_end   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (vs_fall) begin
          state_nxt   = ST_FRAME;
          frame_start = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FRAME: begin
        if (vs_rise) begin
          frame_end = 1'b1;
          state_nxt = snap ? ST_HOLD : ST_IDLE;
        end else if (hr_rise) begin
          line_start = 1'b1;
          state_nxt  = ST_LINE;
        end else begin
          state_nxt = ST_FRAME;
        end
      end
      ST_LINE: begin
        // vsync rise wins over href so a truncated line never emits its partial pixel
        if (vs_rise) begin
          frame_end = 1'b1;
          state_nxt = snap ? ST_HOLD : ST_IDLE;
        end else if (href) begin
          byte_in = 1'b1;
        end else begin
          line_end  = 1'b1;
          state_nxt = ST_FRAME;
        end
      end
      ST_HOLD: begin
        if (!snap) state_nxt = ST_IDLE;
        else       state_nxt = ST_HOLD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vsync_d     <= 1'b0;
      href_d      <= 1'b0;
      phase       <= 1'b0;
      hi_byte     <= 8'd0;
      fmt_lat     <= FMT_RGB332;
      in_col      <= 16'd0;
      in_row      <= 16'd0;
      col         <= 16'd0;
      row         <= 16'd0;
      wr_addr     <= '0;
      row_base    <= '0;
      mem_px_addr <= '0;
      mem_px_data <= '0;
      px_wr       <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= 8'd0;
      frozen      <= 1'b0;
      err_geom    <= 1'b0;
    end else begin
      vsync_d    <= vsync;
      href_d     <= href;
      px_wr      <= 1'b0;
      frame_done <= 1'b0;
      frozen     <= (state_nxt == ST_HOLD);
      if (frame_start) begin
        fmt_lat  <= fmt_e'(fmt);
        in_row   <= 16'd0;
        row      <= 16'd0;
        wr_addr  <= '0;
        row_base <= '0;
      end
      if (line_start) begin
        hi_byte <= px_data;
        phase   <= 1'b1;
        in_col  <= 16'd0;
        col     <= 16'd0;
      end
      if (byte_in) begin
        phase <= ~phase;
        if (!phase) begin
          hi_byte <= px_data;
        end else begin
          in_col <= sat_inc(in_col);
          if (keep_px) begin
            col <= sat_inc(col);
            if (wr_ok) begin
              px_wr       <= 1'b1;
              mem_px_addr <= wr_addr;
              mem_px_data <= px_conv;
              wr_addr     <= wr_addr + AW'(1);
            end
          end
        end
      end
      if (line_end) begin
        phase  <= 1'b0;
        in_row <= sat_inc(in_row);
        if (phase) err_geom <= 1'b1;
        if (keep_line) begin
          row <= sat_inc(row);
          if (in_col != H_IN) err_geom <= 1'b1;
          // realign to the next row start so short or long lines cannot skew later rows
          if (row < V_LIM) begin
            row_base <= row_base + H_STEP;
            wr_addr  <= row_base + H_STEP;
          end
        end
      end
      if (frame_end) begin
        phase      <= 1'b0;
        frame_done <= 1'b1;
        if (in_row != 16'd0) frame_cnt <= frame_cnt + 8'd1;
        if (row != V_LIM)    err_geom  <= 1'b1;
      end
    end
  end

endmodule
